// File: rtl/zion_pc_set_arbiter.sv
// -----------------------------------------------------------------------------
// zion_pc_set_arbiter
//
// Purpose:
//   Program-counter set channel. Merges CH_NUM redirect channels into one fetch
//   PC. Channel 0 has the highest priority. The PC reaches the fetch stage
//   through a valid/ready handshake. After each accepted fetch the PC advances
//   by INC. Each redirect can optionally be followed by FLUSH_CYC bubble cycles.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous reset, active-low
//   iSetEn     per-channel redirect request
//   iSetPc     per-channel target, channel k at [k*PC_W +: PC_W]
//   iFetchRdy  fetch accepts oPc this cycle
//   oPc        current fetch PC
//   oPcVld     oPc valid for fetch
//   oRedirect  one-cycle pulse after oPc was loaded from a channel
//   oSelCh     one-hot winner of the last redirect, held until the next one
//   oBusy      flush bubble in progress
//   oMisalign  (ZION_PC_SET_ALIGN_CHK_EN only) one-cycle pulse when the winning
//              target is not a multiple of INC and was discarded
//
// Configuration macro:
//   ZION_PC_SET_ALIGN_CHK_EN - enables the target alignment check and oMisalign.
// -----------------------------------------------------------------------------
module zion_pc_set_arbiter #(
    parameter int RV64      = 0,
    parameter int CH_NUM    = 3,
    parameter int INC       = 4,
    parameter int FLUSH_CYC = 1,
    localparam int PC_W     = 32 * (1 + RV64),
    parameter logic [PC_W-1:0] RST_PC = {PC_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH_NUM-1:0]      iSetEn,
    input  logic [CH_NUM*PC_W-1:0] iSetPc,
    input  logic                   iFetchRdy,
    output logic [PC_W-1:0]        oPc,
    output logic                   oPcVld,
    output logic                   oRedirect,
    output logic [CH_NUM-1:0]      oSelCh,
    output logic                   oBusy
`ifdef ZION_PC_SET_ALIGN_CHK_EN
    ,
    output logic                   oMisalign
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e              state_r;
    state_e              state_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_s;
    logic [PC_W-1:0]     pc_s;
    logic [CH_NUM-1:0]   sel_s;
    logic                redir_s;
    logic                vld_s;
    logic                busy_s;
    logic                win_found_s;
    logic [PC_W-1:0]     win_pc_s;
    logic [CH_NUM-1:0]   win_sel_s;
    logic                take_s;

`ifdef ZION_PC_SET_ALIGN_CHK_EN
    localparam logic [PC_W-1:0] INC_PC = PC_W'(INC);
    logic                misalign_s;
`endif

    // Fixed-priority pick: the lowest-index requesting channel wins.
    always_comb begin
        win_found_s = 1'b0;
        win_pc_s    = {PC_W{1'b0}};
        win_sel_s   = {CH_NUM{1'b0}};
        for (int k = 0; k < CH_NUM; k++) begin
            if (iSetEn[k] && !win_found_s) begin
                win_found_s  = 1'b1;
                win_pc_s     = iSetPc[k*PC_W +: PC_W];
                win_sel_s[k] = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the INIT/RUN/FLUSH controller.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pc_s    = oPc;
        sel_s   = oSelCh;
        redir_s = 1'b0;
`ifdef ZION_PC_SET_ALIGN_CHK_EN
        // A misaligned winner also suppresses every lower-priority channel.
        misalign_s = win_found_s && ((win_pc_s % INC_PC) != {PC_W{1'b0}});
        take_s     = win_found_s && !misalign_s;
`else
        take_s     = win_found_s;
`endif

        if (take_s) begin
            // A redirect wins over advance in every state. An accepted fetch in the
            // same cycle is consumed, and its increment is dropped.
            pc_s    = win_pc_s;
            sel_s   = win_sel_s;
            redir_s = 1'b1;
            if (FLUSH_CYC > 0) begin
                state_s = ST_FLUSH;
                cnt_s   = 4'(FLUSH_CYC);
            end else begin
                state_s = ST_RUN;
                cnt_s   = 4'd0;
            end
        end
`ifdef ZION_PC_SET_ALIGN_CHK_EN
        else if (misalign_s) begin
            // The discarded redirect freezes the controller for this cycle.
            state_s = state_r;
            cnt_s   = cnt_r;
        end
`endif
        else begin
            case (state_r)
                ST_INIT: begin
                    state_s = ST_RUN;
                end
                ST_RUN: begin
                    if (iFetchRdy) begin
                        pc_s = oPc + PC_W'(INC);
                    end else begin
                        pc_s = oPc;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r <= 4'd1) begin
                        state_s = ST_RUN;
                        cnt_s   = 4'd0;
                    end else begin
                        cnt_s   = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_s = ST_INIT;
                    cnt_s   = 4'd0;
                end
            endcase
        end

        vld_s  = (state_s == ST_RUN);
        busy_s = (state_s == ST_FLUSH);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_INIT;
            cnt_r     <= 4'd0;
            oPc       <= RST_PC;
            oPcVld    <= 1'b0;
            oRedirect <= 1'b0;
            oSelCh    <= {CH_NUM{1'b0}};
            oBusy     <= 1'b0;
`ifdef ZION_PC_SET_ALIGN_CHK_EN
            oMisalign <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            oPc       <= pc_s;
            oPcVld    <= vld_s;
            oRedirect <= redir_s;
            oSelCh    <= sel_s;
            oBusy     <= busy_s;
`ifdef ZION_PC_SET_ALIGN_CHK_EN
            oMisalign <= misalign_s;
`endif
        end
    end

endmodule
